color_match: RTL
================

COLOR_MATCH -- requirements
Module: color_match

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 640, pixels per line.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 480, lines per frame.
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_hue  input  16  hue, degrees, unsigned 10.6 fixed point.
REQ-006 SHALL have port i_sat  input  16  saturation, percent, unsigned 10.6.
REQ-007 SHALL have port i_value  input  16  value, percent, unsigned 10.6.
REQ-008 SHALL have port i_valid  input  1  HSV pixel valid.
REQ-009 SHALL have port i_sof  input  1  start of frame; qualified by i_valid; marks the first pixel.
REQ-010 SHALL have ports i_hue_lo and i_hue_hi  input  16  hue window bounds, 10.6.
REQ-011 SHALL have ports i_sat_min and i_val_min  input  16  minimum saturation and value, 10.6.
REQ-012 SHALL have port o_mask  output  1  pixel matched.
REQ-013 SHALL have port o_valid  output  1  o_mask valid.
REQ-014 SHALL have port o_frame_done  output  1  one-cycle pulse; frame statistics updated.
REQ-015 SHALL have port o_count  output  20  matched pixels in the last complete frame.
REQ-016 SHALL have ports o_xmin, o_xmax, o_ymin, o_ymax  output  11 each  bounding box of matched pixels.
REQ-017 SHALL have port o_found  output  1  last complete frame had o_count > 0.

Function
REQ-018 Thresholds SHALL be latched into shadow registers on each valid i_sof pixel; that pixel and the rest of its frame use the shadow values; mid-frame changes have no effect.
REQ-019 Hue match: if hue_lo <= hue_hi, match SHALL be hue_lo <= hue <= hue_hi; otherwise (wrap through 0), match SHALL be hue >= hue_lo OR hue <= hue_hi.
REQ-020 Mask SHALL equal hue match AND sat >= sat_min AND value >= val_min; all comparisons unsigned and inclusive.
REQ-021 Pipeline SHALL have 2 stages: stage 1 registers the compare results; stage 2 registers o_mask/o_valid. o_valid equals i_valid delayed by exactly 2 cycles, with no bubbles.
REQ-022 Before the first i_sof, pixels SHALL produce o_mask=0 with o_valid asserted.
REQ-023 FSM SHALL have states IDLE, ACTIVE, DONE.
REQ-024 IDLE -> ACTIVE SHALL occur on a valid i_sof: x=0, y=0, accumulators cleared, then the pixel is accumulated.
REQ-025 In ACTIVE, each valid pixel SHALL advance x. At x=FRAME_WIDTH-1, x wraps to 0 and y increments.
REQ-026 ACTIVE -> DONE SHALL occur on the stage-2 pixel at x=FRAME_WIDTH-1, y=FRAME_HEIGHT-1.
REQ-027 DONE SHALL last 1 cycle, copy the accumulators to the outputs, pulse o_frame_done, and return to IDLE.
REQ-028 A valid i_sof in ACTIVE SHALL abort the frame: no o_frame_done, outputs keep their previous values, and the pixel restarts the frame at x=0, y=0.
REQ-029 Valid pixels in IDLE that are not i_sof SHALL be excluded from statistics.
REQ-030 Accumulation per matched pixel: count+1 (saturating at 2^20-1); xmin=min, xmax=max, ymin=min, ymax=max. The first match of a frame initialises all four bounds.
REQ-031 If a frame has no match, DONE SHALL output count=0, o_found=0, and bbox=0.
REQ-032 o_frame_done SHALL occur 1 cycle after the o_valid of the last pixel.
REQ-033 Statistic outputs SHALL hold between pulses.
REQ-034 i_valid deasserted SHALL stall x/y and accumulators; gaps of any length are allowed.

Reset
REQ-035 While i_rst is high: FSM=IDLE, pipeline flushed, and all outputs 0 (o_mask, o_valid, o_frame_done, o_count, bbox, o_found).
REQ-036 Reset mid-frame SHALL discard the frame; no o_frame_done is produced for it.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=2 unless stated)
REQ-037 Thresholds hue 0x1A00..0x2200 (104..136 deg), sat_min 0x0C80, val_min 0x0C80; pixel hue 0x1E00, sat 0x1900, val 0x1900 -> o_mask=1 two cycles later; same pixel with sat 0x0C7F -> o_mask=0.
REQ-038 Wrap window hue_lo=0x5000 (320 deg), hue_hi=0x0500 (20 deg) -> hues 0x0000, 0x0500, 0x59C0 match; 0x0501 and 0x4FFF do not.
REQ-039 8-pixel frame, matches at (1,0) and (2,1) -> o_frame_done 1 cycle after the 8th o_valid; count=2, xmin=1, xmax=2, ymin=0, ymax=1, found=1.
REQ-040 i_valid toggled 1-0-0-1 throughout a frame -> same statistics as the gapless frame; o_valid pattern equals i_valid delayed by 2.
REQ-041 i_sof reasserted after 5 pixels, then a full 8-pixel frame -> exactly one o_frame_done, with statistics from the second frame only.
REQ-042 i_rst pulsed 1 cycle after 3 pixels of a frame -> all outputs 0 next cycle; no o_frame_done until a new i_sof frame completes.

Source files
------------

// File: rtl/color_match.sv
// rtl/color_match.sv - HSV colour-window matcher with per-frame match count and bounding box.
module color_match #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_hue,
    input  logic [15:0] i_sat,
    input  logic [15:0] i_value,
    input  logic        i_valid,
    input  logic        i_sof,
    input  logic [15:0] i_hue_lo,
    input  logic [15:0] i_hue_hi,
    input  logic [15:0] i_sat_min,
    input  logic [15:0] i_val_min,
    output logic        o_mask,
    output logic        o_valid,
    output logic        o_frame_done,
    output logic [19:0] o_count,
    output logic [10:0] o_xmin,
    output logic [10:0] o_xmax,
    output logic [10:0] o_ymin,
    output logic [10:0] o_ymax,
    output logic        o_found
);
    localparam logic [10:0] X_LAST = 11'(FRAME_WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    logic [15:0] sh_hue_lo, sh_hue_hi, sh_sat_min, sh_val_min;
    logic        armed;
    logic        take;
    logic [15:0] hue_lo, hue_hi, sat_min, val_min;
    logic        hue_ok, match_c;
    logic        s1_valid, s1_match, s1_sof, s2_sof;

    // The sof pixel itself must see the new thresholds, so bypass the shadow on that cycle.
    assign take    = i_valid & i_sof;
    assign hue_lo  = take ? i_hue_lo  : sh_hue_lo;
    assign hue_hi  = take ? i_hue_hi  : sh_hue_hi;
    assign sat_min = take ? i_sat_min : sh_sat_min;
    assign val_min = take ? i_val_min : sh_val_min;
    assign hue_ok  = (hue_lo <= hue_hi) ? ((i_hue >= hue_lo) && (i_hue <= hue_hi))
                                        : ((i_hue >= hue_lo) || (i_hue <= hue_hi));
    assign match_c = (armed | take) & hue_ok & (i_sat >= sat_min) & (i_value >= val_min);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            armed      <= 1'b0;
            sh_hue_lo  <= '0;
            sh_hue_hi  <= '0;
            sh_sat_min <= '0;
            sh_val_min <= '0;
            s1_valid   <= 1'b0;
            s1_match   <= 1'b0;
            s1_sof     <= 1'b0;
            o_valid    <= 1'b0;
            o_mask     <= 1'b0;
            s2_sof     <= 1'b0;
        end else begin
            if (take) begin
                armed      <= 1'b1;
                sh_hue_lo  <= i_hue_lo;
                sh_hue_hi  <= i_hue_hi;
                sh_sat_min <= i_sat_min;
                sh_val_min <= i_val_min;
            end
            s1_valid <= i_valid;
            s1_match <= i_valid & match_c;
            s1_sof   <= take;
            o_valid  <= s1_valid;
            o_mask   <= s1_match;
            s2_sof   <= s1_sof;
        end
    end

    state_t      state, state_n;
    logic [10:0] x, y, x_n, y_n;
    logic [19:0] cnt, cnt_n;
    logic [10:0] bx0, bx1, by0, by1, bx0_n, bx1_n, by0_n, by1_n;
    logic        any, any_n;
    logic        publish;
    logic        start, in_frame, last;
    logic [10:0] px, py;

    // Statistics follow the stage-2 pixel stream so they line up with o_valid/o_mask.
    assign start    = o_valid & s2_sof;
    assign in_frame = start | (state == ACTIVE);
    assign px       = start ? 11'd0 : x;
    assign py       = start ? 11'd0 : y;
    assign last     = (px == X_LAST) && (py == Y_LAST);

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        cnt_n   = cnt;
        bx0_n   = bx0;
        bx1_n   = bx1;
        by0_n   = by0;
        by1_n   = by1;
        any_n   = any;
        publish = 1'b0;
        if (state == DONE) state_n = IDLE;
        if (o_valid && in_frame) begin
            if (start) begin
                cnt_n = '0;
                bx0_n = '0;
                bx1_n = '0;
                by0_n = '0;
                by1_n = '0;
                any_n = 1'b0;
            end
            if (o_mask) begin
                if (cnt_n != '1) cnt_n = cnt_n + 20'd1;
                if (!any_n || px < bx0_n) bx0_n = px;
                if (!any_n || px > bx1_n) bx1_n = px;
                if (!any_n || py < by0_n) by0_n = py;
                if (!any_n || py > by1_n) by1_n = py;
                any_n = 1'b1;
            end
            if (last) begin
                state_n = DONE;
                publish = 1'b1;
            end else begin
                state_n = ACTIVE;
                if (px == X_LAST) begin
                    x_n = '0;
                    y_n = py + 11'd1;
                end else begin
                    x_n = px + 11'd1;
                    y_n = py;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            cnt     <= '0;
            bx0     <= '0;
            bx1     <= '0;
            by0     <= '0;
            by1     <= '0;
            any     <= 1'b0;
            o_count <= '0;
            o_xmin  <= '0;
            o_xmax  <= '0;
            o_ymin  <= '0;
            o_ymax  <= '0;
            o_found <= 1'b0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            cnt   <= cnt_n;
            bx0   <= bx0_n;
            bx1   <= bx1_n;
            by0   <= by0_n;
            by1   <= by1_n;
            any   <= any_n;
            if (publish) begin
                o_count <= cnt_n;
                o_xmin  <= bx0_n;
                o_xmax  <= bx1_n;
                o_ymin  <= by0_n;
                o_ymax  <= by1_n;
                o_found <= any_n;
            end
        end
    end

    assign o_frame_done = (state == DONE);
endmodule
